// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch Wishbone responder:
//   - register offsets inside the 16-byte window (selected by adr[3:2])
//   - STATUS register field positions
//   - responder FSM state type
//   - helper that assembles the STATUS read word
// ---------------------------------------------------------------------------
package watch_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CFG    = 2'd1;
  localparam logic [1:0] REG_TIME   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_CNT_LSB = 8;
  localparam int CHG_CNT_W      = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  // STATUS = {16'h0, chg_cnt[7:0], 7'h0, err}
  function automatic logic [31:0] pack_status(input logic [CHG_CNT_W-1:0] cnt,
                                              input logic err);
    logic [31:0] w_word;
    w_word = '0;
    w_word[STATUS_CNT_LSB +: CHG_CNT_W] = cnt;
    w_word[STATUS_ERR_BIT] = err;
    return w_word;
  endfunction

endpackage

// File: rtl/watch_chg_counter.sv
// ---------------------------------------------------------------------------
// watch_chg_counter
// Counts how often the BCD time input changes, saturating at all-ones.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_time   current BCD time from the watch
//   i_clr    clear request (asserted during the ack cycle of a STATUS read)
//   o_cnt    current change count
// ---------------------------------------------------------------------------
module watch_chg_counter
  import watch_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [15:0]          i_time,
  input  logic                 i_clr,
  output logic [CHG_CNT_W-1:0] o_cnt
);

  logic [15:0]          r_time_q;
  logic [CHG_CNT_W-1:0] r_cnt;
  logic                 w_change;
  logic                 w_sat;

  assign w_change = (i_time != r_time_q);
  assign w_sat    = &r_cnt;

  // A change arriving in the same cycle as a clear must not be lost, so the
  // clear lands on 1 instead of 0 in that case.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_time_q <= '0;
      r_cnt    <= '0;
    end else begin
      r_time_q <= i_time;
      if (i_clr) begin
        r_cnt <= w_change ? CHG_CNT_W'(1) : '0;
      end else if (w_change && !w_sat) begin
        r_cnt <= r_cnt + CHG_CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/watch_wb_responder.sv
// ---------------------------------------------------------------------------
// watch_wb_responder
// Wishbone classic slave for the ASIC watch: decodes a 16-byte register
// window at BASE_ADDR and answers every request with a single-cycle ack.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i         bus cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i         byte lanes, byte address
//   wbs_dat_i / wbs_dat_o        write data / read data (zero unless acking)
//   wbs_ack_o                    one-cycle acknowledge
//   time_i                       BCD time from the watch
//   cfg_o, cfg_valid_o           counter preset and its load strobe
//   watch_rst_o                  soft reset to the watch, active high
// Registers (adr[3:2]): CTRL, CFG, TIME (read-only), STATUS.
// ---------------------------------------------------------------------------
module watch_wb_responder
  import watch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [11:0] CFG_RESET = 12'h000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] time_i,
  output logic [11:0] cfg_o,
  output logic        cfg_valid_o,
  output logic        watch_rst_o
);

  state_e               r_state;
  logic                 r_hit;
  logic                 r_we;
  logic [1:0]           r_off;
  logic [11:0]          r_cfg;
  logic                 r_cfg_valid;
  logic                 r_watch_rst;
  logic                 r_err;

  logic                 w_req;
  logic                 w_hit;
  logic                 w_wr;
  logic [1:0]           w_off;
  logic                 w_status_clr;
  logic [31:0]          w_rdata;
  logic [CHG_CNT_W-1:0] w_chg_cnt;
  logic                 w_unused;

  assign wbs_ack_o = (r_state == S_ACK);
  assign w_req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign w_hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off     = wbs_adr_i[3:2];
  assign w_wr      = w_req & w_hit & wbs_we_i;

  // Byte offset, upper lanes and upper data bits carry no register state.
  assign w_unused  = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:12]};

  // Two-state responder: every sampled request gets exactly one ack cycle,
  // and the ack cycle itself never accepts a new request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_req) r_state <= S_ACK;
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Remember what is being acked so read data can be formed during the ack
  // cycle from live values (TIME and the change count).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_hit <= 1'b0;
      r_we  <= 1'b0;
      r_off <= REG_CTRL;
    end else if (w_req) begin
      r_hit <= w_hit;
      r_we  <= wbs_we_i;
      r_off <= w_off;
    end
  end

  // Writes take effect on the request edge so the new cfg_o and its load
  // strobe are both visible in the ack cycle. An unmapped access setting err
  // takes priority over any clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cfg       <= CFG_RESET;
      r_cfg_valid <= 1'b0;
      r_watch_rst <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_cfg_valid <= w_wr && (w_off == REG_CFG) && (|wbs_sel_i[1:0]);
      if (w_wr && (w_off == REG_CTRL) && wbs_sel_i[0]) begin
        r_watch_rst <= wbs_dat_i[0];
      end
      if (w_wr && (w_off == REG_CFG)) begin
        if (wbs_sel_i[0]) r_cfg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_cfg[11:8] <= wbs_dat_i[11:8];
      end
      if (w_req && !w_hit) begin
        r_err <= 1'b1;
      end else if (w_wr && (w_off == REG_STATUS) && wbs_sel_i[0] &&
                   wbs_dat_i[STATUS_ERR_BIT]) begin
        r_err <= 1'b0;
      end
    end
  end

  // The count is shown during the ack cycle and cleared at its end.
  assign w_status_clr = wbs_ack_o & r_hit & ~r_we & (r_off == REG_STATUS);

  watch_chg_counter u_chg_counter (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_time  (time_i),
    .i_clr   (w_status_clr),
    .o_cnt   (w_chg_cnt)
  );

  // Read data is gated by ack, so the bus sees zero outside ack cycles and
  // for writes or unmapped accesses.
  always_comb begin
    w_rdata = '0;
    if (wbs_ack_o && r_hit && !r_we) begin
      case (r_off)
        REG_CTRL:   w_rdata = {31'h0, r_watch_rst};
        REG_CFG:    w_rdata = {20'h0, r_cfg};
        REG_TIME:   w_rdata = {16'h0, time_i};
        REG_STATUS: w_rdata = pack_status(w_chg_cnt, r_err);
        default:    w_rdata = '0;
      endcase
    end
  end

  assign wbs_dat_o   = w_rdata;
  assign cfg_o       = r_cfg;
  assign cfg_valid_o = r_cfg_valid;
  assign watch_rst_o = r_watch_rst;

endmodule
